// File: rtl/evm_pkg.sv
// Shared definitions for the EVM result display: mode encoding and
// winner-scan FSM states.
package evm_pkg;

    typedef enum logic [1:0] {
        MODE_VOTE   = 2'd0,
        MODE_MANUAL = 2'd1,
        MODE_SCAN   = 2'd2,
        MODE_WINNER = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } win_state_e;

endpackage

// File: rtl/evm_prio_sel.sv
// Lowest-index priority select: reports whether any request bit is set and
// the index of the lowest set bit (bit 0 wins).
module evm_prio_sel #(
    parameter int N     = 6,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    // Scan upwards and latch the first request seen
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i_req[i] && !o_valid) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/evm_result_display.sv
// EVM result display: vote acknowledge, manual result, auto-scan and
// winner search over packed candidate vote counts.
// Optional feature macro: EVM_WINNER_EN (mode 3 winner scan, busy, winner_tie).
// Without it mode 3 behaves as manual result and busy/winner_tie are 0.
module evm_result_display
    import evm_pkg::*;
#(
    parameter  int NUM_CAND    = 6,
    parameter  int VOTE_W      = 8,
    parameter  int HOLD_CYCLES = 100000000,
    localparam int IDX_W       = $clog2(NUM_CAND)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [1:0]                 i_mode,
    input  logic                       i_valid_vote_casted,
    input  logic [NUM_CAND*VOTE_W-1:0] i_cand_votes,
    input  logic [NUM_CAND-1:0]        i_button_pressed,
    output logic [VOTE_W-1:0]          o_result,
    output logic [IDX_W-1:0]           o_result_idx,
    output logic                       o_winner_tie,
    output logic                       o_busy
);

    localparam int              HOLD_W   = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_CAND - 1);

    logic [VOTE_W-1:0] w_cnt [NUM_CAND];
    logic              w_btn_valid;
    logic [IDX_W-1:0]  w_btn_idx;
    logic [IDX_W-1:0]  w_scan_sel;
    logic [VOTE_W-1:0] w_res_next;
    logic [IDX_W-1:0]  w_idx_next;

    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] r_dwell;
    logic [IDX_W-1:0]  r_scan_idx;
    logic [VOTE_W-1:0] r_result;
    logic [IDX_W-1:0]  r_result_idx;

    // Unpack the flat count bus into per-candidate counts
    always_comb begin
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            w_cnt[i] = i_cand_votes[i*VOTE_W +: VOTE_W];
        end
    end

    evm_prio_sel #(
        .N     (NUM_CAND),
        .IDX_W (IDX_W)
    ) u_prio_sel (
        .i_req   (i_button_pressed),
        .o_valid (w_btn_valid),
        .o_idx   (w_btn_idx)
    );

    // Vote acknowledge hold counter, runs regardless of mode
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold <= '0;
        end else if (i_valid_vote_casted) begin
            r_hold <= HOLD_W'(1);
        end else if (r_hold == HOLD_MAX) begin
            r_hold <= '0;
        end else if (r_hold != '0) begin
            r_hold <= r_hold + HOLD_W'(1);
        end
    end

    // Auto-scan index and dwell; parked at 0 outside mode 2 so entry starts at 0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scan_idx <= '0;
            r_dwell    <= '0;
        end else if (i_mode != MODE_SCAN) begin
            r_scan_idx <= '0;
            r_dwell    <= '0;
        end else if (w_btn_valid) begin
            // the press cycle is the first cycle of the new dwell
            r_scan_idx <= w_btn_idx;
            r_dwell    <= HOLD_W'(1);
        end else if (r_dwell == HOLD_MAX) begin
            r_scan_idx <= (r_scan_idx == IDX_LAST) ? '0 : r_scan_idx + IDX_W'(1);
            r_dwell    <= '0;
        end else begin
            r_dwell <= r_dwell + HOLD_W'(1);
        end
    end

    assign w_scan_sel = w_btn_valid ? w_btn_idx : r_scan_idx;

`ifdef EVM_WINNER_EN
    win_state_e        r_state;
    win_state_e        w_state_next;
    logic [IDX_W-1:0]  r_cnt;
    logic [VOTE_W-1:0] r_best;
    logic [IDX_W-1:0]  r_best_idx;
    logic              r_tie;
    logic [VOTE_W-1:0] w_cur;
    logic [VOTE_W-1:0] w_cand_best;
    logic [IDX_W-1:0]  w_cand_idx;
    logic              w_cand_tie;
    logic              w_scan_last;

    // Winner FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Winner FSM next state: any departure from mode 3 returns to IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (i_mode == MODE_WINNER) w_state_next = ST_SCAN;
            ST_SCAN: begin
                if (i_mode != MODE_WINNER) w_state_next = ST_IDLE;
                else if (r_cnt == IDX_LAST) w_state_next = ST_DONE;
            end
            ST_DONE: if (i_mode != MODE_WINNER) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Compare the candidate under r_cnt against the running best
    always_comb begin
        w_cur       = w_cnt[r_cnt];
        w_cand_best = r_best;
        w_cand_idx  = r_best_idx;
        w_cand_tie  = r_tie;
        if (r_cnt == '0 || w_cur > r_best) begin
            w_cand_best = w_cur;
            w_cand_idx  = r_cnt;
            w_cand_tie  = 1'b0;
        end else if (w_cur == r_best) begin
            w_cand_tie = 1'b1;
        end
    end

    assign w_scan_last = (r_state == ST_SCAN) && (w_state_next == ST_DONE);

    // Scan counter and running best
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_tie      <= 1'b0;
        end else begin
            r_cnt <= (r_state == ST_SCAN && w_state_next == ST_SCAN) ? r_cnt + IDX_W'(1) : '0;
            if (r_state == ST_SCAN) begin
                r_best     <= w_cand_best;
                r_best_idx <= w_cand_idx;
                r_tie      <= w_cand_tie;
            end
        end
    end

    assign o_busy       = (r_state == ST_SCAN);
    assign o_winner_tie = (r_state == ST_DONE) && r_tie;
`else
    assign o_busy       = 1'b0;
    assign o_winner_tie = 1'b0;
`endif

    // Next displayed value per mode; default holds the previous value
    always_comb begin
        w_res_next = r_result;
        w_idx_next = r_result_idx;
        case (i_mode)
            MODE_VOTE: begin
                w_res_next = (i_valid_vote_casted || r_hold != '0) ? '1 : '0;
                w_idx_next = '0;
            end
            MODE_MANUAL: begin
                if (w_btn_valid) begin
                    w_res_next = w_cnt[w_btn_idx];
                    w_idx_next = w_btn_idx;
                end
            end
            MODE_SCAN: begin
                w_res_next = w_cnt[w_scan_sel];
                w_idx_next = w_scan_sel;
            end
            default: begin
`ifdef EVM_WINNER_EN
                if (w_scan_last) begin
                    w_res_next = w_cand_best;
                    w_idx_next = w_cand_idx;
                end
`else
                if (w_btn_valid) begin
                    w_res_next = w_cnt[w_btn_idx];
                    w_idx_next = w_btn_idx;
                end
`endif
            end
        endcase
    end

    // Registered display outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_result     <= '0;
            r_result_idx <= '0;
        end else begin
            r_result     <= w_res_next;
            r_result_idx <= w_idx_next;
        end
    end

    assign o_result     = r_result;
    assign o_result_idx = r_result_idx;

endmodule

// File: tb/tb_evm_result_display.sv
// Self-checking bench for evm_result_display (NUM_CAND=6, VOTE_W=8, HOLD_CYCLES=4).
module tb_evm_result_display;

    localparam int NC = 6;
    localparam int VW = 8;
    localparam int HC = 4;
    localparam int IW = $clog2(NC);

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [1:0]      mode  = 2'd0;
    logic            pulse = 1'b0;
    logic [NC*VW-1:0] votes = '0;
    logic [NC-1:0]   btn   = '0;
    logic [VW-1:0]   result;
    logic [IW-1:0]   result_idx;
    logic            winner_tie;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    evm_result_display #(
        .NUM_CAND    (NC),
        .VOTE_W      (VW),
        .HOLD_CYCLES (HC)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_mode              (mode),
        .i_valid_vote_casted (pulse),
        .i_cand_votes        (votes),
        .i_button_pressed    (btn),
        .o_result            (result),
        .o_result_idx        (result_idx),
        .o_winner_tie        (winner_tie),
        .o_busy              (busy)
    );

    typedef struct {
        logic [1:0]    mode;
        logic [NC-1:0] btn;
        logic [VW-1:0] res;
        int            idx;
    } vec_t;

    vec_t tab[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm, input int er, input int ei, input int eb, input int et);
        chk({nm, ".result"}, 32'(result), 32'(er));
        chk({nm, ".idx"}, 32'(result_idx), 32'(ei));
        chk({nm, ".busy"}, 32'(busy), 32'(eb));
        chk({nm, ".tie"}, 32'(winner_tie), 32'(et));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] cnt_of(input int i);
        return votes[i*VW +: VW];
    endfunction

    function automatic int lowest(input logic [NC-1:0] b);
        for (int i = 0; i < NC; i++) if (b[i]) return i;
        return -1;
    endfunction

    task automatic load_counts(input logic [VW-1:0] c[NC]);
        for (int i = 0; i < NC; i++) votes[i*VW +: VW] = c[i];
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        mode  = 2'd0;
        pulse = 1'b0;
        btn   = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Winner reference: maximum count, lowest index holding it, tie if shared
    task automatic winner_ref(input logic [VW-1:0] s[NC], output int val, output int idx, output int tie);
        int n;
        val = 0;
        for (int i = 0; i < NC; i++) if (int'(s[i]) > val) val = int'(s[i]);
        idx = -1;
        n   = 0;
        for (int i = 0; i < NC; i++) begin
            if (int'(s[i]) == val) begin
                n++;
                if (idx < 0) idx = i;
            end
        end
        tie = (n > 1) ? 1 : 0;
    endtask

`ifdef EVM_WINNER_EN
    // Counts switch from a to b after step sw; candidate i is sampled at step i+2
    task automatic run_scan(input string nm, input logic [VW-1:0] a[NC], input logic [VW-1:0] b[NC], input int sw);
        logic [VW-1:0] smp[NC];
        int rv, ri, rt;
        for (int i = 0; i < NC; i++) smp[i] = (i >= sw - 1) ? b[i] : a[i];
        winner_ref(smp, rv, ri, rt);
        load_counts(a);
        mode = 2'd1;
        btn  = NC'(8);
        step();
        chk_all({nm, "_pre"}, int'(a[3]), 3, 0, 0);
        mode = 2'd3;
        btn  = '0;
        for (int t = 1; t <= NC; t++) begin
            step();
            chk_all({nm, "_scan"}, int'(a[3]), 3, 1, 0);
            if (t == sw) load_counts(b);
        end
        for (int t = 0; t < 2; t++) begin
            step();
            chk_all({nm, "_done"}, rv, ri, 0, rt);
        end
        mode = 2'd0;
        step();
        chk_all({nm, "_exit"}, 0, 0, 0, 0);
    endtask
`endif

    // Behavioural model state for the randomized phase
    int            m_cyc, m_last_pulse, m_aidx, m_at, m_prev;
    int            e_res, e_idx;

    task automatic model_reset();
        m_cyc        = 0;
        m_last_pulse = -1000;
        m_aidx       = 0;
        m_at         = 0;
        m_prev       = -1;
        e_res        = 0;
        e_idx        = 0;
    endtask

    // Expected outputs after the coming edge, given the inputs now driven
    task automatic model_step();
        int lb, cur;
        if (pulse) m_last_pulse = m_cyc;
        lb = lowest(btn);
        case (int'(mode))
            0: begin
                e_res = (m_cyc + 1 - m_last_pulse <= HC) ? 255 : 0;
                e_idx = 0;
            end
            2: begin
                if (m_prev != 2) begin m_aidx = 0; m_at = m_cyc; end
                if (lb >= 0) begin m_aidx = lb; m_at = m_cyc; end
                cur   = (m_aidx + (m_cyc - m_at) / HC) % NC;
                e_res = int'(cnt_of(cur));
                e_idx = cur;
            end
            default: begin
                if (lb >= 0) begin
                    e_res = int'(cnt_of(lb));
                    e_idx = lb;
                end
            end
        endcase
        m_prev = int'(mode);
        m_cyc++;
    endtask

    initial begin
        logic [VW-1:0] ca[NC];
        logic [VW-1:0] cb[NC];
        int max_mode;

        // Reset state
        #2 rst_n = 1'b0;
        #1 chk_all("reset_async", 0, 0, 0, 0);
        step();
        chk_all("reset_held", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven manual-mode vectors
        ca = '{8'd3, 8'd7, 8'd9, 8'd1, 8'd0, 8'd2};
        load_counts(ca);
        tab.push_back('{2'd1, 6'b000110, 8'd7, 1});
        tab.push_back('{2'd1, 6'b000000, 8'd7, 1});
        tab.push_back('{2'd1, 6'b100000, 8'd2, 5});
        tab.push_back('{2'd1, 6'b010001, 8'd3, 0});
        tab.push_back('{2'd1, 6'b001000, 8'd1, 3});
        tab.push_back('{2'd1, 6'b010000, 8'd0, 4});
        tab.push_back('{2'd0, 6'b111111, 8'd0, 0});
        tab.push_back('{2'd1, 6'b000000, 8'd0, 0});
        tab.push_back('{2'd1, 6'b000100, 8'd9, 2});
`ifndef EVM_WINNER_EN
        tab.push_back('{2'd3, 6'b000010, 8'd7, 1});
        tab.push_back('{2'd3, 6'b000000, 8'd7, 1});
        tab.push_back('{2'd3, 6'b000100, 8'd9, 2});
`endif
        foreach (tab[k]) begin
            mode = tab[k].mode;
            btn  = tab[k].btn;
            step();
            chk_all($sformatf("tab%0d", k), int'(tab[k].res), tab[k].idx, 0, 0);
        end
        btn = '0;

        // Vote acknowledge: single pulse, then two overlapping pulses
        mode = 2'd0;
        for (int t = 1; t <= 7; t++) begin
            pulse = (t == 1);
            step();
            chk_all("ack_single", (t <= HC) ? 255 : 0, 0, 0, 0);
        end
        for (int t = 1; t <= 9; t++) begin
            pulse = (t == 1 || t == 3);
            step();
            chk_all("ack_retrig", (t <= 2 + HC) ? 255 : 0, 0, 0, 0);
        end
        pulse = 1'b0;

        // Pulse in manual mode, switch into vote mode mid-hold
        mode = 2'd1;
        for (int t = 1; t <= 6; t++) begin
            pulse = (t == 1);
            if (t == 3) mode = 2'd0;
            step();
            if (t >= 3) chk_all("ack_late_entry", (t <= HC) ? 255 : 0, 0, 0, 0);
        end

        // Auto-scan: dwell and wrap, then a mid-dwell press
        mode = 2'd2;
        for (int t = 1; t <= 26; t++) begin
            step();
            chk_all("scan_walk", int'(ca[((t - 1) / HC) % NC]), ((t - 1) / HC) % NC, 0, 0);
        end
        btn = NC'(16);
        for (int t = 27; t <= 36; t++) begin
            step();
            btn = '0;
            chk_all("scan_press", int'(ca[(4 + (t - 27) / HC) % NC]), (4 + (t - 27) / HC) % NC, 0, 0);
        end

        // Reset mid-hold discards the acknowledge
        mode  = 2'd0;
        pulse = 1'b1;
        step();
        pulse = 1'b0;
        chk_all("hold_pre_reset", 255, 0, 0, 0);
        do_reset();
        #1 chk_all("hold_in_reset", 0, 0, 0, 0);
        step();
        chk_all("hold_after_reset", 0, 0, 0, 0);

`ifdef EVM_WINNER_EN
        ca = '{8'd5, 8'd9, 8'd9, 8'd2, 8'd0, 8'd1};
        run_scan("win_tie", ca, ca, 100);
        ca = '{8'd5, 8'd9, 8'd3, 8'd4, 8'd0, 8'd1};
        run_scan("win_clear", ca, ca, 100);
        ca = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        run_scan("win_zero", ca, ca, 100);
        ca = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd255};
        run_scan("win_last", ca, ca, 100);
        ca = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        cb = '{8'd50, 8'd1, 8'd1, 8'd1, 8'd1, 8'd9};
        run_scan("win_midchg", ca, cb, 2);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NC; i++) ca[i] = VW'($urandom_range(0, 3));
            run_scan("win_rand", ca, ca, 100);
        end

        // Abort: leave mode 3 after three scan cycles
        ca = '{8'd3, 8'd7, 8'd9, 8'd1, 8'd0, 8'd2};
        load_counts(ca);
        mode = 2'd1;
        btn  = NC'(1);
        step();
        chk_all("abort_pre", 3, 0, 0, 0);
        mode = 2'd3;
        btn  = '0;
        for (int t = 1; t <= 3; t++) begin
            step();
            chk_all("abort_scan", 3, 0, 1, 0);
        end
        mode = 2'd1;
        btn  = NC'(4);
        step();
        chk_all("abort_exit", 9, 2, 0, 0);
        btn = '0;
        step();
        chk_all("abort_hold", 9, 2, 0, 0);

        // Reset mid-scan
        mode = 2'd3;
        step();
        step();
        chk_all("rst_scan_pre", 9, 2, 1, 0);
        do_reset();
        #1 chk_all("rst_scan_in", 0, 0, 0, 0);
        step();
        chk_all("rst_scan_after", 0, 0, 0, 0);
        max_mode = 2;
`else
        max_mode = 3;
`endif

        // Randomized phase against the behavioural model
        do_reset();
        model_reset();
        for (int seg = 0; seg < 25; seg++) begin
            int len;
            mode = 2'($urandom_range(0, max_mode));
            len  = $urandom_range(3, 20);
            for (int k = 0; k < len; k++) begin
                pulse = ($urandom_range(0, 7) == 0);
                btn   = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '0;
                if ($urandom_range(0, 4) == 0) begin
                    for (int i = 0; i < NC; i++) votes[i*VW +: VW] = VW'($urandom);
                end
                model_step();
                step();
                chk_all($sformatf("rand_m%0d", int'(mode)), e_res, e_idx, 0, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/evm_result_display.md
EVM_RESULT_DISPLAY -- requirements
Module: evm_result_display

Interface
REQ-001 Parameter NUM_CAND, default 6, number of candidates; legal range 2..16.
REQ-002 Parameter VOTE_W, default 8, width of each vote count.
REQ-003 Parameter HOLD_CYCLES, default 100000000, length of each acknowledge hold and each scan dwell, in clocks; legal range ≥2.
REQ-004 clock  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset; assertion immediate, deassertion synchronous to clock.
REQ-006 mode  in  2  0=vote, 1=manual result, 2=auto-scan, 3=winner.
REQ-007 valid_vote_casted  in  1  single-cycle pulse when a vote is accepted.
REQ-008 cand_votes  in  NUM_CAND*VOTE_W  packed counts; candidate i at bits [i*VOTE_W +: VOTE_W].
REQ-009 button_pressed  in  NUM_CAND  candidate select buttons; bit 0 = highest priority.
REQ-010 result  out  VOTE_W  displayed value.
REQ-011 result_idx  out  IDX_W  candidate index shown; IDX_W = clog2(NUM_CAND).
REQ-012 winner_tie  out  1  high when the max count is shared by two or more candidates.
REQ-013 busy  out  1  high while a winner scan is running.

Function
REQ-014 Hold counter: loads 1 on valid_vote_casted; increments while nonzero and < HOLD_CYCLES-1; clears at HOLD_CYCLES-1; a new pulse mid-hold restarts it at 1.
REQ-015 Mode 0: result = all-ones while hold counter nonzero or a pulse is present this cycle, else 0; result_idx = 0.
REQ-016 Mode 1: result/result_idx register the lowest-index pressed button's count/index, one-cycle latency; no button pressed → hold the previous value.
REQ-017 Mode 2: index starts at 0 on entry and advances every HOLD_CYCLES clocks, wrapping from NUM_CAND-1 to 0; result = count of the current index, one-cycle latency; any button press jumps to the lowest pressed index and restarts the dwell.
REQ-018 Mode 3 entry (mode changes to 3) starts a winner scan: FSM IDLE→SCAN→DONE; SCAN compares one candidate per clock, taking NUM_CAND cycles; busy high exactly during SCAN.
REQ-019 Scan rule: strictly greater count replaces the best; an equal count keeps the lower index and sets the tie flag; all-zero counts give index 0 with tie=1.
REQ-020 DONE: result = best count, result_idx = best index, winner_tie valid; outputs held until mode leaves 3; DONE→IDLE on mode exit.
REQ-021 During SCAN, result/result_idx hold their pre-scan values; vote changes mid-scan are not restarted; the scan completes with sampled-per-cycle counts.
REQ-022 Mode leaving 3 mid-scan aborts to IDLE; busy=0 next cycle; winner_tie=0.
REQ-023 winner_tie=0 in all modes except mode 3 DONE.
REQ-024 Hold counter runs in all modes; changing into mode 0 mid-hold shows all-ones for the remaining hold.

Reset
REQ-025 On reset: result=0, result_idx=0, winner_tie=0, busy=0, hold counter=0, scan index=0, FSM=IDLE.
REQ-026 Reset asserted mid-scan or mid-hold discards all progress with no further output change until released.

Configuration
REQ-027 EVM_WINNER_EN defined: mode 3 winner scan, busy and winner_tie as specified.
REQ-028 EVM_WINNER_EN undefined: no FSM or comparator logic; mode 3 behaves as mode 1; busy and winner_tie tied to 0.

Structure
REQ-029 Shared package evm_pkg holds the mode encoding constants (MODE_VOTE, MODE_MANUAL, MODE_SCAN, MODE_WINNER) and the winner FSM state enum.
REQ-030 One sub-module, evm_prio_sel, for the lowest-index one-hot priority select (pressed flag plus index), reused by modes 1 and 2.

Verification
REQ-031 Mode 0, HOLD_CYCLES=10, pulse at cycle 0 → result 0xFF for cycles 1..10, then 0x00; a second pulse at cycle 5 extends all-ones to cycle 15.
REQ-032 Mode 1, counts 3,7,9,1,0,2, buttons 0b000110 → result=7, result_idx=1; buttons released → result stays 7.
REQ-033 Mode 2, HOLD_CYCLES=4 → result_idx 0,1,2,3,4,5,0 every 4 cycles; pressing button 4 mid-dwell → idx 4, dwell restarts.
REQ-034 Mode 3, counts 5,9,9,2,0,1 → busy for 6 cycles, then result=9, result_idx=1, winner_tie=1; counts 5,9,3,... → idx 1, tie=0.
REQ-035 Mode 3 entered, mode→1 after 3 scan cycles → busy=0 next cycle, mode 1 behaviour resumes; reset mid-scan → all outputs 0.
REQ-036 Build without EVM_WINNER_EN, mode 3 with button 2 pressed → result = count 2, busy=0, winner_tie=0.
